// File: rtl/pong_pkg.sv
// Shared definitions for the Pong rule engine and its renderers.
//   game_state_t : match FSM encoding (IDLE=0 .. GAME_OVER=4)
//   DEF_*        : default screen / paddle geometry
//   speed_dx()   : per-frame horizontal step for a difficulty level
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  localparam int DEF_SCREEN_W  = 800;
  localparam int DEF_SCREEN_H  = 600;
  localparam int DEF_BALL_SIZE = 16;
  localparam int DEF_PADDLE_W  = 16;
  localparam int DEF_PADDLE_H  = 96;
  localparam int DEF_P1_X      = 32;
  localparam int DEF_P2_X      = 752;

  // Speed table: level 0..3 -> dx 2/3/4/6; dy is always dx-1.
  function automatic logic [3:0] speed_dx(input logic [1:0] level);
    case (level)
      2'd0:    return 4'd2;
      2'd1:    return 4'd3;
      2'd2:    return 4'd4;
      default: return 4'd6;
    endcase
  endfunction

endpackage

// File: rtl/pong_game_fsm_if.sv
// Player-input / game-output bundle of the Pong rule engine.
//   master : drives vsync, paddle positions, mode, difficulty, buttons
//   slave  : the rule engine; drives ball/paddle positions, scores, state
interface pong_game_fsm_if #(
  parameter int SCORE_W = 4
);
  logic               vsync_in;
  logic [11:0]        p1_ypos;
  logic [11:0]        p2_ypos_in;
  logic               cpu_mode;
  logic [1:0]         difficulty;
  logic               button;
  logic               mouse_left;

  logic [11:0]        ball_xpos;
  logic [11:0]        ball_ypos;
  logic [11:0]        p2_ypos;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [2:0]         game_state;
  logic               game_over;
  logic               point_pulse;

  modport master (
    output vsync_in, p1_ypos, p2_ypos_in, cpu_mode, difficulty, button, mouse_left,
    input  ball_xpos, ball_ypos, p2_ypos, score_p1, score_p2, game_state, game_over,
           point_pulse
  );

  modport slave (
    input  vsync_in, p1_ypos, p2_ypos_in, cpu_mode, difficulty, button, mouse_left,
    output ball_xpos, ball_ypos, p2_ypos, score_p1, score_p2, game_state, game_over,
           point_pulse
  );
endinterface

// File: rtl/pong_game_fsm_frame_tick.sv
// pong_frame_tick: two-flop vsync synchroniser with a one-clock pulse on
// the rising edge of vsync.
//   clk, rst (async, active low), vsync_in -> tick
module pong_frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);
  logic vsync_s1_reg;
  logic vsync_s2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_s1_reg <= 1'b0;
      vsync_s2_reg <= 1'b0;
    end else begin
      vsync_s1_reg <= vsync_in;
      vsync_s2_reg <= vsync_s1_reg;
    end
  end

  assign tick = vsync_s1_reg & ~vsync_s2_reg;
endmodule

// File: rtl/pong_game_fsm.sv
// pong_game_fsm: Pong rule engine. Match FSM (idle/serve/play/point/game
// over), frame-stepped ball motion with wall and paddle bounces, scoring,
// and a second paddle driven either by the player or by CPU tracking.
//   clk, rst (async, active low)
//   bus (slave): vsync/paddles/mode/difficulty/buttons in;
//                ball/paddle-2 positions, scores, state, game_over,
//                point_pulse out (all registered)
module pong_game_fsm
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int P1_X         = DEF_P1_X,
  parameter int P2_X         = DEF_P2_X,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int CPU_STEP     = 3
) (
  input logic            clk,
  input logic            rst,
  pong_game_fsm_if.slave bus
);
  // 13-bit geometry constants so the bounce/overlap sums never wrap
  localparam logic [12:0] C_W         = 13'(SCREEN_W);
  localparam logic [12:0] C_H         = 13'(SCREEN_H);
  localparam logic [12:0] C_BALL      = 13'(BALL_SIZE);
  localparam logic [12:0] C_PAD_H     = 13'(PADDLE_H);
  localparam logic [12:0] C_P1_EDGE   = 13'(P1_X + PADDLE_W);
  localparam logic [12:0] C_P2_X      = 13'(P2_X);
  localparam logic [12:0] C_HALF_BALL = 13'(BALL_SIZE / 2);
  localparam logic [12:0] C_HALF_PAD  = 13'(PADDLE_H / 2);
  localparam logic [12:0] C_P2_MAX    = 13'(SCREEN_H - PADDLE_H);
  localparam logic [12:0] C_STEP      = 13'(CPU_STEP);
  localparam logic [11:0] BALL_X0     = 12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_Y0     = 12'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [11:0] P1_HIT_X    = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] P2_HIT_X    = 12'(P2_X - BALL_SIZE);
  localparam logic [11:0] P2_Y0       = 12'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [11:0] P2_MAX12    = 12'(SCREEN_H - PADDLE_H);
  localparam logic [15:0] SERVE_LAST  = 16'(SERVE_FRAMES - 1);
  localparam logic [15:0] POINT_LAST  = 16'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] C_WIN = SCORE_W'(WIN_SCORE);

  game_state_t        state_reg, state_next;
  logic [11:0]        x_reg, x_next, y_reg, y_next, p2_reg, p2_next;
  logic               right_reg, right_next, down_reg, down_next;
  logic [SCORE_W-1:0] s1_reg, s1_next, s2_reg, s2_next;
  logic [15:0]        cnt_reg, cnt_next;
  logic               pulse_reg, pulse_next, game_over_reg;
  logic               start_prev_reg, start_evt_reg;
  logic               tick;

  pong_frame_tick u_tick (.clk(clk), .rst(rst), .vsync_in(bus.vsync_in), .tick(tick));

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == C_WIN) ? s : s + 1'b1;
  endfunction

  // ---------------- play step (one tick of ball motion) ----------------
  logic [3:0]  dx, dy;
  logic [12:0] x_w, y_w, p1_w, p2_w, dx_w, dy_w, y_play_w;
  logic [11:0] y_play, x_play;
  logic        down_play, right_play, hit1, hit2, miss_left, miss_right;

  assign dx     = speed_dx(bus.difficulty);
  assign dy     = dx - 4'd1;
  assign dx_w   = {9'd0, dx};
  assign dy_w   = {9'd0, dy};
  assign x_w    = {1'b0, x_reg};
  assign y_w    = {1'b0, y_reg};
  assign p1_w   = {1'b0, bus.p1_ypos};
  assign p2_w   = {1'b0, p2_reg};

  always_comb begin
    y_play    = y_reg;
    down_play = down_reg;
    if (!down_reg) begin
      if (y_w <= dy_w) begin
        y_play    = 12'd0;
        down_play = 1'b1;
      end else begin
        y_play = y_reg - {8'd0, dy};
      end
    end else begin
      if (y_w + C_BALL >= C_H - dy_w) begin
        y_play    = BALL_Y_MAX;
        down_play = 1'b0;
      end else begin
        y_play = y_reg + {8'd0, dy};
      end
    end
  end

  // Paddle overlap is tested against the already-moved ball row.
  assign y_play_w = {1'b0, y_play};
  assign hit1 = (y_play_w + C_BALL > p1_w) && (y_play_w < p1_w + C_PAD_H);
  assign hit2 = (y_play_w + C_BALL > p2_w) && (y_play_w < p2_w + C_PAD_H);

  always_comb begin
    x_play     = x_reg;
    right_play = right_reg;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    if (!right_reg) begin
      if (x_w <= C_P1_EDGE && hit1) begin
        x_play     = P1_HIT_X;
        right_play = 1'b1;
      end else if (x_w <= dx_w) begin
        miss_left = 1'b1;
      end else begin
        x_play = x_reg - {8'd0, dx};
      end
    end else begin
      if (x_w + C_BALL >= C_P2_X && hit2) begin
        x_play     = P2_HIT_X;
        right_play = 1'b0;
      end else if (x_w + C_BALL >= C_W - dx_w) begin
        miss_right = 1'b1;
      end else begin
        x_play = x_reg + {8'd0, dx};
      end
    end
  end

  // ---------------- CPU paddle tracking ----------------
  logic [12:0] cpu_center, cpu_target_w, cpu_move_w;
  logic [11:0] cpu_move;

  assign cpu_center = y_w + C_HALF_BALL;

  always_comb begin
    cpu_target_w = (cpu_center <= C_HALF_PAD) ? 13'd0 : cpu_center - C_HALF_PAD;
    if (cpu_target_w > C_P2_MAX) cpu_target_w = C_P2_MAX;
    cpu_move_w = p2_w;
    if (p2_w < cpu_target_w)
      cpu_move_w = (cpu_target_w - p2_w <= C_STEP) ? cpu_target_w : p2_w + C_STEP;
    else if (p2_w > cpu_target_w)
      cpu_move_w = (p2_w - cpu_target_w <= C_STEP) ? cpu_target_w : p2_w - C_STEP;
    // p2 may arrive out of range from the player input when switching to CPU
    cpu_move = (cpu_move_w > C_P2_MAX) ? P2_MAX12 : cpu_move_w[11:0];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (start_evt_reg) state_next = ST_SERVE;
      ST_SERVE:     if (start_evt_reg || (tick && cnt_reg == SERVE_LAST)) state_next = ST_PLAY;
      ST_PLAY:      if (tick && (miss_left || miss_right)) state_next = ST_POINT;
      ST_POINT:     if (tick && cnt_reg == POINT_LAST)
                      state_next = (s1_reg == C_WIN || s2_reg == C_WIN) ? ST_GAME_OVER : ST_SERVE;
      ST_GAME_OVER: if (start_evt_reg) state_next = ST_SERVE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath ----------------
  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    right_next = right_reg;
    down_next  = down_reg;
    s1_next    = s1_reg;
    s2_next    = s2_reg;
    pulse_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_SERVE: begin
        x_next = BALL_X0;
        y_next = BALL_Y0;
      end
      ST_PLAY: if (tick) begin
        y_next    = y_play;
        down_next = down_play;
        // On a miss the ball stays where it left the field; the next serve
        // heads toward the player who just conceded... i.e. the scorer's opponent.
        if (miss_left) begin
          s2_next    = sat_inc(s2_reg);
          pulse_next = 1'b1;
          right_next = 1'b0;
        end else if (miss_right) begin
          s1_next    = sat_inc(s1_reg);
          pulse_next = 1'b1;
          right_next = 1'b1;
        end else begin
          x_next     = x_play;
          right_next = right_play;
        end
      end
      ST_GAME_OVER: if (start_evt_reg) begin
        s1_next = '0;
        s2_next = '0;
      end
      default: ;
    endcase

    if (state_next != state_reg)
      cnt_next = 16'd0;
    else if (tick && (state_reg == ST_SERVE || state_reg == ST_POINT))
      cnt_next = cnt_reg + 16'd1;
    else
      cnt_next = cnt_reg;

    if (!bus.cpu_mode) p2_next = bus.p2_ypos_in;
    else if (tick)     p2_next = cpu_move;
    else               p2_next = p2_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg          <= BALL_X0;
      y_reg          <= BALL_Y0;
      p2_reg         <= P2_Y0;
      right_reg      <= 1'b1;
      down_reg       <= 1'b1;
      s1_reg         <= '0;
      s2_reg         <= '0;
      cnt_reg        <= 16'd0;
      pulse_reg      <= 1'b0;
      game_over_reg  <= 1'b0;
      start_prev_reg <= 1'b0;
      start_evt_reg  <= 1'b0;
    end else begin
      x_reg          <= x_next;
      y_reg          <= y_next;
      p2_reg         <= p2_next;
      right_reg      <= right_next;
      down_reg       <= down_next;
      s1_reg         <= s1_next;
      s2_reg         <= s2_next;
      cnt_reg        <= cnt_next;
      pulse_reg      <= pulse_next;
      game_over_reg  <= (state_next == ST_GAME_OVER);
      start_prev_reg <= bus.button | bus.mouse_left;
      start_evt_reg  <= (bus.button | bus.mouse_left) & ~start_prev_reg;
    end
  end

  assign bus.ball_xpos   = x_reg;
  assign bus.ball_ypos   = y_reg;
  assign bus.p2_ypos     = p2_reg;
  assign bus.score_p1    = s1_reg;
  assign bus.score_p2    = s2_reg;
  assign bus.game_state  = state_reg;
  assign bus.game_over   = game_over_reg;
  assign bus.point_pulse = pulse_reg;
endmodule

// File: tb/tb_pong_game_fsm.sv
// Self-checking bench for pong_game_fsm: reset values, serve timing,
// a per-difficulty speed table, a long randomized match against a
// behavioural rule model, and an asynchronous reset during play.
module tb_pong_game_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pong_game_fsm_if #(.SCORE_W(4)) bus ();

  pong_game_fsm dut (.clk(clk), .rst(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (bus.point_pulse) pulse_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    bus.vsync_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.vsync_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic press_start(input bit use_mouse);
    if (use_mouse) bus.mouse_left = 1'b1;
    else           bus.button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mouse_left = 1'b0;
    bus.button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;
  int m_st, m_x, m_y, m_right, m_down, m_s1, m_s2, m_cnt, m_p2;
  int m_points = 0;

  function automatic int clamp_pad(input int v);
    if (v < 0) return 0;
    if (v > 504) return 504;
    return v;
  endfunction

  function automatic int speed(input int diff);
    int t [4];
    t = '{2, 3, 4, 6};
    return t[diff];
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_x = 392; m_y = 292; m_right = 1; m_down = 1;
    m_s1 = 0; m_s2 = 0; m_cnt = 0; m_p2 = 252;
  endtask

  task automatic model_centre_serve();
    m_st = M_SERVE; m_cnt = 0; m_x = 392; m_y = 292;
  endtask

  task automatic model_start();
    if (m_st == M_IDLE) model_centre_serve();
    else if (m_st == M_SERVE) begin m_st = M_PLAY; m_cnt = 0; end
    else if (m_st == M_OVER) begin m_s1 = 0; m_s2 = 0; model_centre_serve(); end
  endtask

  task automatic model_frame(input int diff, input int p1, input int cpu, input int p2_in);
    int dx, dy, old_y, tgt;
    bit h1, h2;
    dx = speed(diff);
    dy = dx - 1;
    old_y = m_y;
    if (cpu == 0) m_p2 = p2_in;
    case (m_st)
      M_SERVE: if (m_cnt == 59) begin m_st = M_PLAY; m_cnt = 0; end else m_cnt++;
      M_POINT: if (m_cnt == 29) begin
                 if (m_s1 == 9 || m_s2 == 9) begin m_st = M_OVER; m_cnt = 0; end
                 else model_centre_serve();
               end else m_cnt++;
      M_PLAY: begin
        if (m_down == 1) begin
          if (m_y + 16 >= 600 - dy) begin m_y = 584; m_down = 0; end else m_y += dy;
        end else begin
          if (m_y <= dy) begin m_y = 0; m_down = 1; end else m_y -= dy;
        end
        h1 = (m_y + 16 > p1) && (m_y < p1 + 96);
        h2 = (m_y + 16 > m_p2) && (m_y < m_p2 + 96);
        if (m_right == 0) begin
          if (m_x <= 48 && h1) begin m_x = 48; m_right = 1; end
          else if (m_x <= dx) begin
            m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9; m_right = 0;
            m_st = M_POINT; m_cnt = 0; m_points++;
            $display("point #%0d to P2, score %0d-%0d", m_points, m_s1, m_s2);
          end else m_x -= dx;
        end else begin
          if (m_x + 16 >= 752 && h2) begin m_x = 736; m_right = 0; end
          else if (m_x + 16 >= 800 - dx) begin
            m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9; m_right = 1;
            m_st = M_POINT; m_cnt = 0; m_points++;
            $display("point #%0d to P1, score %0d-%0d", m_points, m_s1, m_s2);
          end else m_x += dx;
        end
      end
      default: ;
    endcase
    if (cpu != 0) begin
      tgt = clamp_pad(old_y + 8 - 48);
      if (m_p2 < tgt) m_p2 = (tgt - m_p2 <= 3) ? tgt : m_p2 + 3;
      else if (m_p2 > tgt) m_p2 = (m_p2 - tgt <= 3) ? tgt : m_p2 - 3;
      m_p2 = clamp_pad(m_p2);
    end
  endtask

  task automatic check_model();
    chk("ball_x", int'(bus.ball_xpos), m_x);
    chk("ball_y", int'(bus.ball_ypos), m_y);
    chk("p2_ypos", int'(bus.p2_ypos), m_p2);
    chk("score_p1", int'(bus.score_p1), m_s1);
    chk("score_p2", int'(bus.score_p2), m_s2);
    chk("state", int'(bus.game_state), m_st);
    chk("game_over", int'(bus.game_over), (m_st == M_OVER) ? 1 : 0);
    chk("point_pulses", pulse_cnt, m_points);
  endtask

  // ---------------- table of per-difficulty first steps ----------------
  typedef struct {
    int diff;
    bit use_mouse;
    int exp_x;
    int exp_y;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int diff, cpu, p1, p2_in, overs;
    vecs[0] = '{0, 1'b0, 394, 293};
    vecs[1] = '{1, 1'b1, 395, 294};
    vecs[2] = '{2, 1'b0, 396, 295};
    vecs[3] = '{3, 1'b1, 398, 297};

    bus.vsync_in = 1'b0; bus.p1_ypos = 12'd252; bus.p2_ypos_in = 12'd252;
    bus.cpu_mode = 1'b0; bus.difficulty = 2'd1; bus.button = 1'b0; bus.mouse_left = 1'b0;

    // Reset values
    #1 do_reset();
    chk("rst_x", int'(bus.ball_xpos), 392);
    chk("rst_y", int'(bus.ball_ypos), 292);
    chk("rst_p2", int'(bus.p2_ypos), 252);
    chk("rst_s1", int'(bus.score_p1), 0);
    chk("rst_s2", int'(bus.score_p2), 0);
    chk("rst_state", int'(bus.game_state), 0);
    chk("rst_over", int'(bus.game_over), 0);
    chk("rst_pulse", int'(bus.point_pulse), 0);
    $display("reset: ball (%0d,%0d) state %0d", bus.ball_xpos, bus.ball_ypos, bus.game_state);

    // Serve timing: IDLE holds without a start, then PLAY after exactly 60 ticks
    repeat (3) do_frame();
    chk("idle_hold", int'(bus.game_state), 0);
    press_start(1'b0);
    chk("serve_entry", int'(bus.game_state), 1);
    repeat (59) do_frame();
    chk("serve_59", int'(bus.game_state), 1);
    do_frame();
    chk("serve_60", int'(bus.game_state), 2);
    chk("play_entry_x", int'(bus.ball_xpos), 392);
    do_frame();
    chk("play_step_x", int'(bus.ball_xpos), 395);
    chk("play_step_y", int'(bus.ball_ypos), 294);
    $display("serve: PLAY after 60 ticks, ball (%0d,%0d)", bus.ball_xpos, bus.ball_ypos);

    // Speed table
    for (int i = 0; i < 4; i++) begin
      do_reset();
      bus.difficulty = 2'(vecs[i].diff);
      press_start(vecs[i].use_mouse);
      press_start(vecs[i].use_mouse);
      chk("tbl_state", int'(bus.game_state), 2);
      do_frame();
      chk("tbl_x", int'(bus.ball_xpos), vecs[i].exp_x);
      chk("tbl_y", int'(bus.ball_ypos), vecs[i].exp_y);
      $display("vec %0d diff=%0d ball (%0d,%0d)", i, vecs[i].diff, bus.ball_xpos, bus.ball_ypos);
    end

    // Randomized match against the rule model
    do_reset();
    model_reset();
    check_model();
    diff = 1; cpu = 0; overs = 0;
    for (int f = 0; f < 4000; f++) begin
      if (f % 150 == 0) begin
        diff = int'($urandom_range(0, 3));
        cpu = int'($urandom_range(0, 1));
      end
      p1 = ($urandom_range(0, 2) == 0) ? clamp_pad(m_y - 40) : int'($urandom_range(0, 504));
      p2_in = ($urandom_range(0, 2) == 0) ? clamp_pad(m_y - 40) : int'($urandom_range(0, 600));
      bus.difficulty = 2'(diff);
      bus.cpu_mode = cpu[0];
      bus.p1_ypos = 12'(p1);
      bus.p2_ypos_in = 12'(p2_in);
      if ($urandom_range(0, 19) == 0) begin
        press_start($urandom_range(0, 1) == 1);
        model_start();
        if (cpu == 0) m_p2 = p2_in;
      end
      do_frame();
      model_frame(diff, p1, cpu, p2_in);
      if (m_st == M_OVER && bus.game_over) overs++;
      check_model();
    end
    $display("random run: %0d points, %0d game-over frames", m_points, overs);

    // Asynchronous reset in the middle of play
    do_reset();
    bus.cpu_mode = 1'b0;
    bus.difficulty = 2'd1;
    press_start(1'b0);
    press_start(1'b0);
    repeat (20) do_frame();
    chk("mid_play_state", int'(bus.game_state), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_x", int'(bus.ball_xpos), 392);
    chk("async_y", int'(bus.ball_ypos), 292);
    chk("async_state", int'(bus.game_state), 0);
    chk("async_s1", int'(bus.score_p1), 0);
    chk("async_s2", int'(bus.score_p2), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("async reset: ball (%0d,%0d) state %0d", bus.ball_xpos, bus.ball_ypos, bus.game_state);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
